// File: rtl/ff_reg_pkg.sv
// Shared defaults for the ff_reg storage element family.
// Holds no logic; instances override SIZE and RESET_VAL individually.
`timescale 1ns/1ps
package ff_reg_pkg;

  localparam int unsigned FF_REG_DEFAULT_SIZE = 2;

endpackage : ff_reg_pkg

// File: rtl/ff_reg.sv
// Write-enabled storage register: loads `in` one clk edge after `write`, otherwise holds.
// No handshake or backpressure; asynchronous active-low clear to RESET_VAL.
`timescale 1ns/1ps
module ff_reg
  import ff_reg_pkg::*;
#(
  parameter int unsigned     SIZE      = FF_REG_DEFAULT_SIZE,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write,
  input  logic [SIZE-1:0] in,
  output logic [SIZE-1:0] out
);

  logic [SIZE-1:0] r_q;

  // Reset release is assumed synchronous to clk at system level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RESET_VAL;
    end else if (write) begin
      r_q <= in;
    end
  end

  assign out = r_q;

endmodule : ff_reg

// File: tb/tb_ff_reg.sv
// Scoreboard bench for ff_reg: a 2-bit default instance and an 8-bit instance with RESET_VAL 8'hA5.
`timescale 1ns/1ps
module tb_ff_reg;

  typedef struct {
    string      name;
    bit         sel8;
    logic [7:0] exp;
  } chk_t;

  logic       clk;
  logic       rst2_n;
  logic       wr2;
  logic [1:0] din2;
  logic [1:0] dout2;
  logic       rst8_n;
  logic       wr8;
  logic [7:0] din8;
  logic [7:0] dout8;

  chk_t exp_q[$];
  event chk_ev;
  int   n_chk;
  int   n_fail;

  ff_reg #(.SIZE(2)) u_dut2 (
    .clk   (clk),
    .reset (rst2_n),
    .write (wr2),
    .in    (din2),
    .out   (dout2)
  );

  ff_reg #(.SIZE(8), .RESET_VAL(8'hA5)) u_dut8 (
    .clk   (clk),
    .reset (rst8_n),
    .write (wr8),
    .in    (din8),
    .out   (dout8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_out(input string nm, input bit sel8, input logic [7:0] v);
    chk_t c;
    c.name = nm;
    c.sel8 = sel8;
    c.exp  = v;
    exp_q.push_back(c);
    -> chk_ev;
  endtask

  // Monitor: samples 1 ns after each check request, away from the clock edge.
  initial begin
    chk_t       c;
    logic [7:0] act;
    n_chk  = 0;
    n_fail = 0;
    forever begin
      @(chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        c   = exp_q.pop_front();
        act = c.sel8 ? dout8 : {6'b0, dout2};
        n_chk++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 8'h%h, expected 8'h%h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    rst2_n = 1'b1;
    wr2    = 1'b0;
    din2   = 2'b00;
    rst8_n = 1'b1;
    wr8    = 1'b0;
    din8   = 8'h00;
    #2;
    rst2_n = 1'b0;
    rst8_n = 1'b0;
    wr2    = 1'b1;
    din2   = 2'b11;
    expect_out("rst2_async", 1'b0, 8'h00);
    expect_out("rst8_async", 1'b1, 8'hA5);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      expect_out("rst2_hold", 1'b0, 8'h00);
    end

    @(negedge clk);
    rst2_n = 1'b1;
    din2   = 2'b01;
    expect_out("rst2_release", 1'b0, 8'h00);
    @(posedge clk);
    expect_out("single_wr", 1'b0, 8'h01);
    @(negedge clk);
    wr2 = 1'b0;
    @(posedge clk);
    expect_out("hold_after_wr", 1'b0, 8'h01);

    @(negedge clk);
    din2 = 2'b10;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      expect_out("hold_in_change", 1'b0, 8'h01);
    end
    @(negedge clk);
    wr2 = 1'b1;
    @(posedge clk);
    expect_out("overwrite", 1'b0, 8'h02);

    @(negedge clk);
    wr2  = 1'b1;
    din2 = 2'b11;
    #2;
    rst2_n = 1'b0;
    expect_out("async_mid_cycle", 1'b0, 8'h00);
    @(posedge clk);
    expect_out("rst_wins_write", 1'b0, 8'h00);

    @(negedge clk);
    rst2_n = 1'b1;
    din2   = 2'b01;
    @(posedge clk);
    expect_out("b2b_01", 1'b0, 8'h01);
    @(negedge clk);
    din2 = 2'b10;
    @(posedge clk);
    expect_out("b2b_10", 1'b0, 8'h02);
    @(negedge clk);
    din2 = 2'b11;
    @(posedge clk);
    expect_out("b2b_11", 1'b0, 8'h03);
    @(negedge clk);
    wr2  = 1'b0;
    din2 = 2'b00;
    @(posedge clk);
    expect_out("b2b_hold", 1'b0, 8'h03);

    @(negedge clk);
    rst8_n = 1'b1;
    expect_out("p8_release", 1'b1, 8'hA5);
    @(posedge clk);
    expect_out("p8_no_write", 1'b1, 8'hA5);
    @(negedge clk);
    wr8  = 1'b1;
    din8 = 8'h3C;
    @(posedge clk);
    expect_out("p8_write", 1'b1, 8'h3C);
    @(negedge clk);
    wr8  = 1'b0;
    din8 = 8'hFF;
    #2;
    rst8_n = 1'b0;
    expect_out("p8_reassert", 1'b1, 8'hA5);
    @(posedge clk);
    expect_out("p8_rst_hold", 1'b1, 8'hA5);

    // Let the monitor drain, bounded so a stuck queue still reaches the summary.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #3;
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d checks pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_ff_reg
